// File: rtl/jk_seq_ctrl.sv
// jk_seq_ctrl: command sequencer that drives the J/K/PR/CLR inputs of an
// external JK flip-flop bank. It supports clear, preset, load, toggle, a
// multi-cycle binary up-count, and an optional multi-cycle serial shift.
// Optional feature: define JK_SEQ_SHIFT_EN to build the SHIFT command (opcode 111).
// When it is not defined, opcode 111 is rejected exactly like opcode 110.
module jk_seq_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd,
    input  logic [WIDTH-1:0] data_in,
    input  logic [3:0]       steps,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] J,
    output logic [WIDTH-1:0] K,
    output logic             PR,
    output logic             CLR,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [2:0] OP_NOP    = 3'b000;
    localparam logic [2:0] OP_CLEAR  = 3'b001;
    localparam logic [2:0] OP_PRESET = 3'b010;
    localparam logic [2:0] OP_LOAD   = 3'b011;
    localparam logic [2:0] OP_COUNT  = 3'b100;
    localparam logic [2:0] OP_TOGGLE = 3'b101;
    localparam logic [2:0] OP_RSVD   = 3'b110;
    localparam logic [2:0] OP_SHIFT  = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DRIVE = 3'd1,
        S_COUNT = 3'd2,
`ifdef JK_SEQ_SHIFT_EN
        S_SHIFT = 3'd3,
`endif
        S_DONE  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             op_illegal;

    // Opcodes that finish with an error pulse instead of touching the bank.
`ifdef JK_SEQ_SHIFT_EN
    assign op_illegal = (op_q == OP_RSVD);
`else
    assign op_illegal = (op_q == OP_RSVD) || (op_q == OP_SHIFT);
`endif

    // State, latched operands and step counter; synchronous reset clears all.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: accept in IDLE, run DRIVE once or COUNT/SHIFT for 'steps' cycles.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d   = cmd;
                    data_d = data_in;
                    cnt_d  = steps;
                    case (cmd)
                        OP_NOP, OP_CLEAR, OP_PRESET, OP_LOAD, OP_TOGGLE:
                            state_d = S_DRIVE;
                        OP_COUNT:
                            state_d = (steps == 4'd0) ? S_DONE : S_COUNT;
`ifdef JK_SEQ_SHIFT_EN
                        OP_SHIFT:
                            state_d = (steps == 4'd0) ? S_DONE : S_SHIFT;
`endif
                        default:
                            state_d = S_DONE;
                    endcase
                end
            end
            S_DRIVE: state_d = S_DONE;
            S_COUNT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = S_DONE;
            end
`ifdef JK_SEQ_SHIFT_EN
            S_SHIFT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = S_DONE;
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Bank drive: idle values unless a driving state applies an operation; reset forces CLR low.
    always_comb begin
        logic carry;
        J     = '0;
        K     = '0;
        PR    = 1'b1;
        CLR   = 1'b1;
        carry = 1'b1;
        if (rst) begin
            CLR = 1'b0;
        end else begin
            case (state_q)
                S_DRIVE: begin
                    case (op_q)
                        OP_CLEAR:  CLR = 1'b0;
                        OP_PRESET: PR  = 1'b0;
                        OP_LOAD: begin
                            J = data_q;
                            K = ~data_q;
                        end
                        OP_TOGGLE: begin
                            J = data_q;
                            K = data_q;
                        end
                        default: ;
                    endcase
                end
                S_COUNT: begin
                    // Ripple carry: bit i toggles when all lower bits are 1.
                    for (int unsigned i = 0; i < unsigned'(WIDTH); i++) begin
                        J[i]  = carry;
                        K[i]  = carry;
                        carry = carry & q_fb[i];
                    end
                end
`ifdef JK_SEQ_SHIFT_EN
                S_SHIFT: begin
                    J[0] = data_q[0];
                    K[0] = ~data_q[0];
                    for (int unsigned i = 1; i < unsigned'(WIDTH); i++) begin
                        J[i] = q_fb[i-1];
                        K[i] = ~q_fb[i-1];
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // Handshake and status flags decoded from the current state.
    always_comb begin
        cmd_ready = (state_q == S_IDLE);
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        err       = (state_q == S_DONE) && op_illegal;
    end

endmodule

// File: tb/tb_jk_seq_ctrl.sv
// tb_jk_seq_ctrl: drives jk_seq_ctrl against a behavioural JK flip-flop bank
// and checks the bank contents against an arithmetic reference of each command.
// JK_SEQ_SHIFT_EN selects the expected behaviour of opcode 111.
module tb_jk_seq_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd;
    logic [W-1:0] data_in;
    logic [3:0]   steps;
    logic [W-1:0] q_fb;
    logic [W-1:0] J, K;
    logic         PR, CLR, busy, done, err;

    logic [W-1:0] bank_q = 4'b1010;
    logic [W-1:0] exp_q;
    int           checks = 0;
    int           errors = 0;

    jk_seq_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd(cmd), .data_in(data_in), .steps(steps), .q_fb(q_fb),
        .J(J), .K(K), .PR(PR), .CLR(CLR),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    assign q_fb = bank_q;

    // External JK bank: clear dominates preset, then Q+ = J&~Q | ~K&Q.
    always @(posedge clk) begin
        if (!CLR)     bank_q <= '0;
        else if (!PR) bank_q <= '1;
        else          bank_q <= (J & ~bank_q) | (~K & bank_q);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // PR and CLR must never be low together.
    always @(negedge clk) begin
        chk("pr_clr_exclusive", 32'({PR, CLR} == 2'b00), 32'd0);
    end

    // Bank value after one cycle of the given operation.
    function automatic logic [W-1:0] ref_next(input logic [2:0] op, input logic [W-1:0] q,
                                              input logic [W-1:0] d);
        case (op)
            3'b001:  return '0;
            3'b010:  return '1;
            3'b011:  return d;
            3'b100:  return q + 1'b1;
            3'b101:  return q ^ d;
            3'b111:  return {q[W-2:0], d[0]};
            default: return q;
        endcase
    endfunction

    task automatic run_cmd(input logic [2:0] op, input logic [W-1:0] d, input logic [3:0] s);
        int   n;
        logic illegal;
        illegal = (op == 3'b110);
`ifndef JK_SEQ_SHIFT_EN
        illegal = illegal || (op == 3'b111);
`endif
        if (illegal)                         n = 0;
        else if (op == 3'b100 || op == 3'b111) n = int'(s);
        else                                 n = 1;

        @(negedge clk);
        chk("ready_idle", cmd_ready, 1);
        chk("busy_idle", busy, 0);
        cmd_valid = 1'b1;
        cmd       = op;
        data_in   = d;
        steps     = s;
        @(negedge clk);
        // Junk on the command inputs while busy must be ignored.
        cmd_valid = 1'($urandom_range(0, 1));
        cmd       = 3'($urandom);
        data_in   = W'($urandom);
        steps     = 4'($urandom);
        for (int i = 0; i < n; i++) begin
            chk("ready_busy", cmd_ready, 0);
            chk("busy_active", busy, 1);
            chk("done_early", done, 0);
            @(negedge clk);
            exp_q = ref_next(op, exp_q, d);
            chk("bank_step", bank_q, exp_q);
        end
        chk("done_pulse", done, 1);
        chk("err_pulse", err, 32'(illegal));
        chk("busy_done", busy, 1);
        chk("ready_done", cmd_ready, 0);
        chk("j_idle_done", J, 0);
        chk("k_idle_done", K, 0);
        chk("bank_done", bank_q, exp_q);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("done_clear", done, 0);
        chk("err_clear", err, 0);
        chk("ready_back", cmd_ready, 1);
        chk("busy_back", busy, 0);
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd       = '0;
        data_in   = '0;
        steps     = '0;
        exp_q     = '0;

        // One reset cycle clears the bank that started at 1010.
        @(negedge clk);
        chk("clr_during_rst", CLR, 0);
        chk("bank_after_rst", bank_q, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_bank", bank_q, 0);

        run_cmd(3'b011, 4'b0110, 4'd0);
        chk("load_0110", bank_q, 4'b0110);

        run_cmd(3'b011, 4'b1101, 4'd0);
        run_cmd(3'b100, 4'b0000, 4'd5);
        chk("count5_wrap", bank_q, 4'b0010);
        run_cmd(3'b100, 4'b0000, 4'd0);
        chk("count0_same", bank_q, 4'b0010);

        run_cmd(3'b010, 4'b0000, 4'd0);
        chk("preset", bank_q, 4'b1111);
        run_cmd(3'b101, 4'b1001, 4'd0);
        chk("toggle_1001", bank_q, 4'b0110);
        run_cmd(3'b110, 4'b1111, 4'd7);
        chk("rsvd_same", bank_q, 4'b0110);
        run_cmd(3'b000, 4'b1111, 4'd0);
        chk("nop_same", bank_q, 4'b0110);
        run_cmd(3'b001, 4'b1111, 4'd0);
        chk("clear", bank_q, 4'b0000);

        // Reset in the middle of a 10-step count aborts it without a done pulse.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd       = 3'b100;
        steps     = 4'd10;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            exp_q = exp_q + 1'b1;
            chk("abort_count_step", bank_q, exp_q);
            chk("abort_no_done_pre", done, 0);
        end
        rst = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        exp_q = '0;
        chk("abort_bank", bank_q, 0);
        chk("abort_ready", cmd_ready, 1);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("abort_no_done", done, 0);
            chk("abort_no_step", bank_q, 0);
        end

        // Serial shift of ones (or an error when SHIFT is not built).
        run_cmd(3'b011, 4'b0001, 4'd0);
        run_cmd(3'b111, 4'b0001, 4'd3);
`ifdef JK_SEQ_SHIFT_EN
        chk("shift_result", bank_q, 4'b1111);
`else
        chk("shift_disabled", bank_q, 4'b0001);
`endif

        // Randomized command stream against the reference.
        for (int i = 0; i < 60; i++) begin
            run_cmd(3'($urandom_range(0, 7)), W'($urandom), 4'($urandom_range(0, 15)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
